// File: rtl/uart_pkg.sv
// Shared UART definitions: frame defaults and the receive/transmit state encoding.
// Used by uart_rx and uart_tx.
package uart_pkg;

    localparam int DEF_DATA_BITS  = 8;
    localparam int DEF_OVERSAMPLE = 16;

    // Start bit + data bits + one stop bit
    localparam int FRAME_BITS = DEF_DATA_BITS + 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/uart_rx_sync_ff.sv
// Multi-stage synchronizer for an asynchronous single-bit input.
// Reset value is a parameter so idle-high lines can preset to 1.
module sync_ff #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= {STAGES{RST_VAL}};
        end else begin
            r_sync[0] <= i_d;
            for (int i = 1; i < STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// Oversampling 8N1 UART receiver with a held ready flag,
// framing-error and overrun pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = DEF_DATA_BITS,
    parameter int OVERSAMPLE  = DEF_OVERSAMPLE,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    input  logic                 rx_clk_en,
    input  logic                 read_enable,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 data_ready,
    output logic                 busy,
    output logic                 frame_error,
    output logic                 overrun
);

    localparam int SCW = $clog2(OVERSAMPLE);
    localparam int BCW = $clog2(DATA_BITS + 1);

    localparam logic [SCW-1:0] MID_START   = SCW'(OVERSAMPLE / 2 - 1);
    localparam logic [SCW-1:0] LAST_SAMPLE = SCW'(OVERSAMPLE - 1);
    localparam logic [BCW-1:0] LAST_BIT    = BCW'(DATA_BITS - 1);

    if (OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0 || FRAME_BITS < 3) begin : g_bad
        $error("uart_rx: OVERSAMPLE must be even and >= 4");
    end

    uart_state_e          r_state;
    uart_state_e          w_state_nxt;
    logic [SCW-1:0]       r_sample_cnt;
    logic [SCW-1:0]       w_sample_nxt;
    logic [BCW-1:0]       r_bit_cnt;
    logic [BCW-1:0]       w_bit_nxt;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] w_shift_nxt;
    logic                 r_rx_prev;
    logic                 w_rx_s;
    logic                 w_load;
    logic                 w_ferr;

    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_data_ready;
    logic                 r_frame_error;
    logic                 r_overrun;

    sync_ff #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (rx),
        .o_q (w_rx_s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_sample_cnt <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_rx_prev    <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_sample_cnt <= w_sample_nxt;
            r_bit_cnt    <= w_bit_nxt;
            r_shift      <= w_shift_nxt;
            if (rx_clk_en) begin
                r_rx_prev <= w_rx_s;
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_sample_nxt = r_sample_cnt;
        w_bit_nxt    = r_bit_cnt;
        w_shift_nxt  = r_shift;
        w_load       = 1'b0;
        w_ferr       = 1'b0;
        if (rx_clk_en) begin
            unique case (r_state)
                S_IDLE: begin
                    // Edge-triggered so a line held low cannot retrigger
                    if (r_rx_prev && !w_rx_s) begin
                        w_state_nxt  = S_START;
                        w_sample_nxt = '0;
                    end
                end
                S_START: begin
                    if (r_sample_cnt == MID_START) begin
                        w_sample_nxt = '0;
                        if (!w_rx_s) begin
                            w_state_nxt = S_DATA;
                            w_bit_nxt   = '0;
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end else begin
                        w_sample_nxt = r_sample_cnt + SCW'(1);
                    end
                end
                S_DATA: begin
                    if (r_sample_cnt == LAST_SAMPLE) begin
                        w_shift_nxt  = {w_rx_s, r_shift[DATA_BITS-1:1]};
                        w_bit_nxt    = r_bit_cnt + BCW'(1);
                        w_sample_nxt = '0;
                        if (r_bit_cnt == LAST_BIT) begin
                            w_state_nxt = S_STOP;
                        end
                    end else begin
                        w_sample_nxt = r_sample_cnt + SCW'(1);
                    end
                end
                S_STOP: begin
                    if (r_sample_cnt == LAST_SAMPLE) begin
                        w_load       = w_rx_s;
                        w_ferr       = !w_rx_s;
                        w_sample_nxt = '0;
                        w_state_nxt  = S_IDLE;
                    end else begin
                        w_sample_nxt = r_sample_cnt + SCW'(1);
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // A new byte takes priority over a coincident acknowledge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_data     <= '0;
            r_data_ready  <= 1'b0;
            r_frame_error <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_frame_error <= w_ferr;
            r_overrun     <= w_load && r_data_ready && !read_enable;
            if (w_load) begin
                r_rx_data    <= r_shift;
                r_data_ready <= 1'b1;
            end else if (read_enable) begin
                r_data_ready <= 1'b0;
            end
        end
    end

    assign rx_data     = r_rx_data;
    assign data_ready  = r_data_ready;
    assign busy        = (r_state != S_IDLE);
    assign frame_error = r_frame_error;
    assign overrun     = r_overrun;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: bit-banged 8N1 frames at 16 clk per bit.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_uart_rx;

    localparam int BIT_CLKS = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       rx_clk_en = 1'b1;
    logic       read_enable = 1'b0;
    logic [7:0] rx_data;
    logic       data_ready;
    logic       busy;
    logic       frame_error;
    logic       overrun;

    int n_chk  = 0;
    int n_pass = 0;

    int n_fe   = 0;
    int n_ovr  = 0;
    int n_rise = 0;
    int n_busy = 0;
    logic r_prev_dr = 1'b0;

    int fe0;
    int ovr0;
    int rise0;
    int busy0;

    uart_rx dut (
        .clk         (clk),
        .rst         (rst),
        .rx          (rx),
        .rx_clk_en   (rx_clk_en),
        .read_enable (read_enable),
        .rx_data     (rx_data),
        .data_ready  (data_ready),
        .busy        (busy),
        .frame_error (frame_error),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    // Each pulse is high for one full cycle, so it is seen at exactly one edge
    always @(posedge clk) begin
        n_fe      <= n_fe + int'(frame_error);
        n_ovr     <= n_ovr + int'(overrun);
        n_rise    <= n_rise + int'(data_ready && !r_prev_dr);
        n_busy    <= n_busy + int'(busy);
        r_prev_dr <= data_ready;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic snap();
        fe0   = n_fe;
        ovr0  = n_ovr;
        rise0 = n_rise;
        busy0 = n_busy;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        tick(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(BIT_CLKS);
        end
        rx = stop;
        tick(BIT_CLKS);
    endtask

    task automatic ack();
        read_enable = 1'b1;
        tick(1);
        read_enable = 1'b0;
    endtask

    initial begin
        tick(3);
        chk("rst_data", 32'(rx_data), 32'h00);
        chk("rst_ready", 32'(data_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_fe", 32'(frame_error), 32'd0);
        chk("rst_ovr", 32'(overrun), 32'd0);
        rst = 1'b0;
        tick(8);
        chk("idle_busy", 32'(busy), 32'd0);

        snap();
        send_byte(8'h03, 1'b1);
        tick(4);
        chk("b03_data", 32'(rx_data), 32'h03);
        chk("b03_ready", 32'(data_ready), 32'd1);
        chk("b03_rise", 32'(n_rise - rise0), 32'd1);
        chk("b03_fe", 32'(n_fe - fe0), 32'd0);
        chk("b03_ovr", 32'(n_ovr - ovr0), 32'd0);
        chk("b03_busy", 32'(busy), 32'd0);
        ack();
        chk("b03_ack", 32'(data_ready), 32'd0);

        snap();
        send_byte(8'h0F, 1'b1);
        tick(4);
        chk("b0f_data", 32'(rx_data), 32'h0F);
        chk("b0f_ready", 32'(data_ready), 32'd1);
        ack();
        chk("b0f_ack", 32'(data_ready), 32'd0);
        send_byte(8'hA5, 1'b1);
        tick(4);
        chk("ba5_data", 32'(rx_data), 32'hA5);
        chk("ba5_ready", 32'(data_ready), 32'd1);
        ack();
        chk("ba5_ack", 32'(data_ready), 32'd0);
        ack();
        chk("ack_noop", 32'(data_ready), 32'd0);
        chk("pair_fe", 32'(n_fe - fe0), 32'd0);
        chk("pair_ovr", 32'(n_ovr - ovr0), 32'd0);

        snap();
        send_byte(8'h55, 1'b1);
        tick(4);
        chk("b55_data", 32'(rx_data), 32'h55);
        chk("b55_ovr", 32'(n_ovr - ovr0), 32'd0);
        send_byte(8'hAA, 1'b1);
        tick(4);
        chk("baa_data", 32'(rx_data), 32'hAA);
        chk("baa_ready", 32'(data_ready), 32'd1);
        chk("baa_ovr", 32'(n_ovr - ovr0), 32'd1);
        chk("baa_fe", 32'(n_fe - fe0), 32'd0);

        snap();
        send_byte(8'h3C, 1'b0);
        tick(4);
        chk("fe_pulse", 32'(n_fe - fe0), 32'd1);
        chk("fe_data", 32'(rx_data), 32'hAA);
        chk("fe_ready", 32'(data_ready), 32'd1);
        chk("fe_rise", 32'(n_rise - rise0), 32'd0);
        snap();
        tick(40 * BIT_CLKS);
        chk("brk_fe", 32'(n_fe - fe0), 32'd0);
        chk("brk_busy_cnt", 32'(n_busy - busy0), 32'd0);
        chk("brk_busy", 32'(busy), 32'd0);
        rx = 1'b1;
        tick(2 * BIT_CLKS);
        chk("brk_rel_busy", 32'(n_busy - busy0), 32'd0);
        ack();
        chk("brk_ack", 32'(data_ready), 32'd0);

        snap();
        rx = 1'b0;
        tick(4);
        rx = 1'b1;
        tick(3 * BIT_CLKS);
        chk("gl_busy_seen", 32'(n_busy - busy0 > 0), 32'd1);
        chk("gl_busy", 32'(busy), 32'd0);
        chk("gl_ready", 32'(data_ready), 32'd0);
        chk("gl_rise", 32'(n_rise - rise0), 32'd0);
        chk("gl_fe", 32'(n_fe - fe0), 32'd0);

        send_byte(8'h42, 1'b1);
        tick(4);
        chk("pre_rst_ready", 32'(data_ready), 32'd1);
        rx = 1'b0;
        tick(BIT_CLKS);
        rx = 1'b1;
        tick(3 * BIT_CLKS);
        chk("mid_busy", 32'(busy), 32'd1);
        snap();
        rst = 1'b1;
        tick(1);
        chk("mr_data", 32'(rx_data), 32'h00);
        chk("mr_ready", 32'(data_ready), 32'd0);
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_fe", 32'(frame_error), 32'd0);
        chk("mr_ovr", 32'(overrun), 32'd0);
        rst = 1'b0;
        tick(8 * BIT_CLKS);
        chk("mr_quiet", 32'(n_fe - fe0 + n_ovr - ovr0 + n_rise - rise0), 32'd0);
        send_byte(8'h81, 1'b1);
        tick(4);
        chk("b81_data", 32'(rx_data), 32'h81);
        chk("b81_ready", 32'(data_ready), 32'd1);
        chk("b81_fe", 32'(n_fe - fe0), 32'd0);
        chk("b81_ovr", 32'(n_ovr - ovr0), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
